cpu_io_bridge: RTL and testbench

Buffered I/O port controller sitting directly downstream of the `cpu` I/O pins (`in_signal`/`in_data`, `out_signal`/`out_data`) and upstream of the external peripheral. Words the CPU writes are queued in an output FIFO and drained over a valid/ready handshake. Words the peripheral supplies are queued in an input FIFO and handed to the CPU on read. A stall output tells the core when a read finds no data or a write finds no space.

---
 rtl/cpu_io_bridge.sv | 143 ++++++++++++++
 tb/tb_cpu_io_bridge.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_io_bridge.sv
// -----------------------------------------------------------------------------
// cpu_io_bridge
//
// Buffered I/O port controller between the CPU I/O pins and an external
// peripheral. CPU writes are queued in an output FIFO that drains to the
// peripheral. Peripheral words are queued in an input FIFO that the CPU reads.
// cpu_stall tells the core that this cycle's read found no data or this cycle's
// write found no space.
//
// Handshake rule (both peripheral-side channels): a word moves on a rising
// clock edge exactly when valid and ready are both high in the cycle before
// that edge. Neither side may make valid depend on ready. While valid is high,
// the data must hold steady until the word moves.
//
// Ports:
//   clk            in   single clock, rising edge
//   reset          in   synchronous, active-high
//   in_signal      in   CPU read request this cycle
//   in_data        out  input FIFO head (0 when the input FIFO is empty)
//   out_signal     in   CPU write request this cycle
//   out_data       in   CPU write word
//   cpu_stall      out  this cycle's request was not serviced
//   ext_out_valid  out  output FIFO non-empty
//   ext_out_data   out  output FIFO head
//   ext_out_ready  in   peripheral takes the head this cycle
//   ext_in_valid   in   peripheral offers a word
//   ext_in_data    in   offered word
//   ext_in_ready   out  input FIFO can take a word
//   out_count      out  output FIFO occupancy (0..DEPTH)
//   in_count       out  input FIFO occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module cpu_io_bridge #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_signal,
    output logic [WIDTH-1:0]           in_data,
    input  logic                       out_signal,
    input  logic [WIDTH-1:0]           out_data,
    output logic                       cpu_stall,
    output logic                       ext_out_valid,
    output logic [WIDTH-1:0]           ext_out_data,
    input  logic                       ext_out_ready,
    input  logic                       ext_in_valid,
    input  logic [WIDTH-1:0]           ext_in_data,
    output logic                       ext_in_ready,
    output logic [$clog2(DEPTH):0]     out_count,
    output logic [$clog2(DEPTH):0]     in_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // ---------------- output FIFO (CPU -> peripheral) ----------------
    logic [WIDTH-1:0] out_mem_q [DEPTH];
    logic [AW-1:0]    out_wptr_q, out_wptr_d;
    logic [AW-1:0]    out_rptr_q, out_rptr_d;
    logic [CW-1:0]    out_cnt_q,  out_cnt_d;
    logic             out_full, out_empty, out_push, out_pop;

    // ---------------- input FIFO (peripheral -> CPU) -----------------
    logic [WIDTH-1:0] in_mem_q [DEPTH];
    logic [AW-1:0]    in_wptr_q, in_wptr_d;
    logic [AW-1:0]    in_rptr_q, in_rptr_d;
    logic [CW-1:0]    in_cnt_q,  in_cnt_d;
    logic             in_full, in_empty, in_push, in_pop;

    // Full/empty come from the registered count only, so a pop in the same
    // cycle never frees room for a push, and a push never feeds a pop.
    assign out_full  = (out_cnt_q == CW'(DEPTH));
    assign out_empty = (out_cnt_q == '0);
    assign in_full   = (in_cnt_q == CW'(DEPTH));
    assign in_empty  = (in_cnt_q == '0);

    assign out_push = out_signal && !out_full;
    assign out_pop  = ext_out_valid && ext_out_ready;
    assign in_push  = ext_in_valid && ext_in_ready;
    assign in_pop   = in_signal && !in_empty;

    // Combinational outputs
    assign ext_out_valid = !out_empty;
    assign ext_out_data  = out_mem_q[out_rptr_q];
    assign ext_in_ready  = !reset && !in_full;
    // Stale storage must never reach the CPU while the FIFO is empty.
    assign in_data       = in_empty ? '0 : in_mem_q[in_rptr_q];
    assign cpu_stall     = (out_signal && out_full) || (in_signal && in_empty);
    assign out_count     = out_cnt_q;
    assign in_count      = in_cnt_q;

    // Next-state: DEPTH is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        out_wptr_d = out_wptr_q;
        out_rptr_d = out_rptr_q;
        out_cnt_d  = out_cnt_q;
        in_wptr_d  = in_wptr_q;
        in_rptr_d  = in_rptr_q;
        in_cnt_d   = in_cnt_q;

        if (out_push) out_wptr_d = out_wptr_q + AW'(1);
        if (out_pop)  out_rptr_d = out_rptr_q + AW'(1);
        case ({out_push, out_pop})
            2'b10:   out_cnt_d = out_cnt_q + CW'(1);
            2'b01:   out_cnt_d = out_cnt_q - CW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase

        if (in_push) in_wptr_d = in_wptr_q + AW'(1);
        if (in_pop)  in_rptr_d = in_rptr_q + AW'(1);
        case ({in_push, in_pop})
            2'b10:   in_cnt_d = in_cnt_q + CW'(1);
            2'b01:   in_cnt_d = in_cnt_q - CW'(1);
            default: in_cnt_d = in_cnt_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            out_wptr_q <= '0;
            out_rptr_q <= '0;
            out_cnt_q  <= '0;
            in_wptr_q  <= '0;
            in_rptr_q  <= '0;
            in_cnt_q   <= '0;
        end else begin
            out_wptr_q <= out_wptr_d;
            out_rptr_q <= out_rptr_d;
            out_cnt_q  <= out_cnt_d;
            in_wptr_q  <= in_wptr_d;
            in_rptr_q  <= in_rptr_d;
            in_cnt_q   <= in_cnt_d;
        end
    end

    // Storage is deliberately not reset; emptiness hides its contents.
    always_ff @(posedge clk) begin
        if (out_push) out_mem_q[out_wptr_q] <= out_data;
        if (in_push)  in_mem_q[in_wptr_q]   <= ext_in_data;
    end

endmodule

// File: tb/tb_cpu_io_bridge.sv
module tb_cpu_io_bridge;

  localparam int DEPTH = 8;
  localparam int W     = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_signal;
  logic [W-1:0]  in_data;
  logic          out_signal;
  logic [W-1:0]  out_data;
  logic          cpu_stall;
  logic          ext_out_valid;
  logic [W-1:0]  ext_out_data;
  logic          ext_out_ready;
  logic          ext_in_valid;
  logic [W-1:0]  ext_in_data;
  logic          ext_in_ready;
  logic [CW-1:0] out_count;
  logic [CW-1:0] in_count;

  cpu_io_bridge #(.DEPTH(DEPTH), .WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_signal     (in_signal),
    .in_data       (in_data),
    .out_signal    (out_signal),
    .out_data      (out_data),
    .cpu_stall     (cpu_stall),
    .ext_out_valid (ext_out_valid),
    .ext_out_data  (ext_out_data),
    .ext_out_ready (ext_out_ready),
    .ext_in_valid  (ext_in_valid),
    .ext_in_data   (ext_in_data),
    .ext_in_ready  (ext_in_ready),
    .out_count     (out_count),
    .in_count      (in_count)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];   // words queued toward the peripheral
  logic [W-1:0] inq_q[$];   // words queued toward the CPU
  int total = 0;
  int bad   = 0;
  int words_out = 0;
  int words_in  = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the queue model for the current inputs.
  task automatic check_all(input string tag);
    logic [W-1:0] e_in_data;
    logic         e_stall;
    e_in_data = (inq_q.size() != 0) ? inq_q[0] : '0;
    e_stall   = (out_signal && exp_q.size() == DEPTH) || (in_signal && inq_q.size() == 0);
    chk({tag, ".ext_out_valid"}, W'(ext_out_valid), W'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk({tag, ".ext_out_data"}, ext_out_data, exp_q[0]);
    chk({tag, ".in_data"}, in_data, e_in_data);
    chk({tag, ".cpu_stall"}, W'(cpu_stall), W'(e_stall));
    chk({tag, ".ext_in_ready"}, W'(ext_in_ready), W'(!reset && inq_q.size() < DEPTH));
    chk({tag, ".out_count"}, W'(out_count), W'(exp_q.size()));
    chk({tag, ".in_count"}, W'(in_count), W'(inq_q.size()));
  endtask

  // Apply the transfer rules at a clock edge using the occupancy before it.
  task automatic model_edge();
    bit opop, opush, ipush, ipop;
    if (reset) begin
      exp_q.delete();
      inq_q.delete();
    end else begin
      opop  = (exp_q.size() != 0) && ext_out_ready;
      opush = out_signal && (exp_q.size() < DEPTH);
      ipush = ext_in_valid && (inq_q.size() < DEPTH);
      ipop  = in_signal && (inq_q.size() != 0);
      if (opop)  begin void'(exp_q.pop_front()); words_out++; end
      if (opush) exp_q.push_back(out_data);
      if (ipop)  begin void'(inq_q.pop_front()); words_in++; end
      if (ipush) inq_q.push_back(ext_in_data);
    end
  endtask

  // One cycle: check mid-cycle, advance at the edge, return just after it.
  task automatic cyc(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    in_signal     = 1'b0;
    out_signal    = 1'b0;
    out_data      = '0;
    ext_out_ready = 1'b0;
    ext_in_valid  = 1'b0;
    ext_in_data   = '0;
  endtask

  // Drain both FIFOs with a cycle budget; an expired budget is a failure.
  task automatic drain(input string tag);
    int n;
    idle_inputs();
    ext_out_ready = 1'b1;
    in_signal     = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || inq_q.size() != 0) && n < 4 * DEPTH) begin
      cyc(tag);
      n++;
    end
    chk({tag, ".drained"}, W'(exp_q.size() + inq_q.size()), '0);
    idle_inputs();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    model_edge();
    #1;

    // Reset state
    cyc("rst");
    chk("rst.ext_in_ready_low", W'(ext_in_ready), W'(0));
    reset = 1'b0;
    #1;
    chk("rst.ext_in_ready_rel", W'(ext_in_ready), W'(1));
    cyc("rel");

    // CPU writes 0x11, 0x22, 0x33 back to back with the peripheral ready
    ext_out_ready = 1'b1;
    out_signal = 1'b1; out_data = W'('h11); cyc("wr11");
    chk("seq.head11", ext_out_data, W'('h11));
    out_data = W'('h22); cyc("wr22");
    chk("seq.head22", ext_out_data, W'('h22));
    out_data = W'('h33); cyc("wr33");
    chk("seq.head33", ext_out_data, W'('h33));
    out_signal = 1'b0;
    cyc("wr_end");
    chk("seq.empty", W'(ext_out_valid), W'(0));

    // Fill the output FIFO, then a ninth write stalls
    ext_out_ready = 1'b0;
    out_signal = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      out_data = {$urandom, $urandom};
      cyc("fill");
    end
    chk("fill.count8", W'(out_count), W'(DEPTH));
    out_data = W'('h99);
    chk("fill.stall9", W'(cpu_stall), W'(1));
    cyc("fill.hold");
    chk("fill.still8", W'(out_count), W'(DEPTH));
    ext_out_ready = 1'b1;
    cyc("fill.pop1");          // pop happens, push still refused
    chk("fill.count7", W'(out_count), W'(DEPTH - 1));
    chk("fill.accept9", W'(cpu_stall), W'(0));
    cyc("fill.push9");
    chk("fill.count_back", W'(out_count), W'(DEPTH - 1));
    out_signal = 1'b0;
    drain("drain1");

    // Read on empty input FIFO, then a peripheral word arrives
    in_signal = 1'b1;
    #1;
    chk("rde.stall", W'(cpu_stall), W'(1));
    chk("rde.data0", in_data, '0);
    ext_in_valid = 1'b1; ext_in_data = W'('hABCD);
    cyc("rde.push");
    ext_in_valid = 1'b0; ext_in_data = '0;
    chk("rde.data", in_data, W'('hABCD));
    chk("rde.nostall", W'(cpu_stall), W'(0));
    cyc("rde.pop");
    chk("rde.count0", W'(in_count), W'(0));
    in_signal = 1'b0;

    // Full output FIFO with push and pop together
    out_signal = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      out_data = {$urandom, $urandom};
      cyc("full.fill");
    end
    out_data = W'('h5A5A);
    ext_out_ready = 1'b1;
    chk("full.stall", W'(cpu_stall), W'(1));
    cyc("full.pushpop");
    chk("full.count", W'(out_count), W'(DEPTH - 1));
    out_signal = 1'b0;
    drain("drain2");

    // Count 3 on both FIFOs, then push+pop together keeps 3
    out_signal = 1'b1; ext_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      out_data = {$urandom, $urandom};
      ext_in_data = {$urandom, $urandom};
      cyc("c3.fill");
    end
    ext_out_ready = 1'b1; in_signal = 1'b1;
    out_data = {$urandom, $urandom};
    ext_in_data = {$urandom, $urandom};
    cyc("c3.both");
    chk("c3.out_count", W'(out_count), W'(3));
    chk("c3.in_count", W'(in_count), W'(3));
    drain("drain3");

    // Fill the input FIFO: ready drops at DEPTH
    ext_in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ext_in_data = {$urandom, $urandom};
      cyc("infill");
    end
    chk("infill.notready", W'(ext_in_ready), W'(0));
    drain("drain4");

    // Random traffic with backpressure on every handshake
    words_out = 0;
    words_in  = 0;
    for (int i = 0; i < 400; i++) begin
      in_signal     = ($urandom_range(0, 2) != 0);
      out_signal    = ($urandom_range(0, 2) != 0);
      ext_out_ready = ($urandom_range(0, 2) != 0);
      // The peripheral holds its offered word until it is taken.
      if (!(ext_in_valid && ext_in_ready)) begin
        if (!ext_in_valid) begin
          ext_in_valid = ($urandom_range(0, 1) != 0);
          ext_in_data  = {$urandom, $urandom};
        end
      end else begin
        ext_in_valid = ($urandom_range(0, 1) != 0);
        ext_in_data  = {$urandom, $urandom};
      end
      out_data = {$urandom, $urandom};
      cyc("rand");
    end
    total++;
    assert (words_out >= 20 && words_in >= 20) else begin
      bad++;
      $error("FAIL rand.volume observed=%0d/%0d expected>=20", words_out, words_in);
    end
    drain("drain5");

    // Reset mid-operation with out_count=5 and in_count=2
    out_signal = 1'b1;
    for (int i = 0; i < 5; i++) begin
      out_data = {$urandom, $urandom};
      ext_in_valid = (i < 2);
      ext_in_data = {$urandom, $urandom};
      cyc("mid.fill");
    end
    idle_inputs();
    chk("mid.out5", W'(out_count), W'(5));
    chk("mid.in2", W'(in_count), W'(2));
    reset = 1'b1;
    #1;
    chk("mid.ready_low", W'(ext_in_ready), W'(0));
    cyc("mid.rst");
    chk("mid.out0", W'(out_count), W'(0));
    chk("mid.in0", W'(in_count), W'(0));
    chk("mid.valid0", W'(ext_out_valid), W'(0));
    chk("mid.in_data0", in_data, '0);
    reset = 1'b0;
    #1;
    chk("mid.ready_rel", W'(ext_in_ready), W'(1));
    cyc("mid.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
